glb_g2f_strm_fifo: RTL and testbench
====================================

# glb_g2f_strm_fifo

Elastic stream buffer on the GLB-to-fabric (g2f) path. It sits between one GLB tile's `strm_data_g2f`/`strm_data_g2f_vld`/`strm_data_g2f_rdy`/`strm_ctrl_g2f` outputs and the matching CGRA IO tile's `io16_g2io`/`io1_g2io` inputs. It decouples GLB read latency from fabric backpressure with a small FIFO and has no combinational ready path. It also aligns the 1-bit control (flush/start) pulse with the buffer clear.

## Interface
- `DATA_WIDTH`, default 16: stream word width (equals `CGRA_DATA_WIDTH`).
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `CNT_WIDTH`, default `$clog2(DEPTH+1)`: occupancy width; derived, not overridden.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  reset; synchronous, active-high.
- `stall`  in  1  when 1, no push, no pop and no pointer/count change; flush still acts.
- `in_data`  in  DATA_WIDTH  word from GLB (`strm_data_g2f`).
- `in_vld`  in  1  word valid from GLB.
- `in_rdy`  out  1  buffer can accept a word.
- `in_ctrl`  in  1  control pulse from GLB (`strm_ctrl_g2f`); 1 = flush.
- `out_data`  out  DATA_WIDTH  head word to fabric.
- `out_vld`  out  1  head valid.
- `out_rdy`  in  1  fabric accepts head.
- `out_ctrl`  out  1  control pulse to fabric, delayed by 1 cycle.
- `count`  out  CNT_WIDTH  current occupancy.
- `stat_bp_cnt`  out  32  backpressure cycle counter (see Configuration).

## Operation
- Storage is a DEPTH-entry register array. Write pointer and read pointer are each `$clog2(DEPTH)` bits and wrap modulo DEPTH. `count` is the authoritative full/empty flag.
- `in_rdy = (count != DEPTH) && !stall`. It is derived only from registers and `stall`, never from `out_rdy`.
- `out_vld = (count != 0) && !stall`. `out_data` = entry at the read pointer, first-word-fall-through.
- Push = `in_vld && in_rdy`: writes entry[wr_ptr] and increments wr_ptr.
- Pop = `out_vld && out_rdy`: increments rd_ptr.
- Simultaneous push and pop: count unchanged and both pointers advance. This is legal at any non-full, non-empty occupancy.
- When full, in_rdy=0, so no push even if a pop occurs that cycle. in_rdy reasserts the cycle after the pop.
- When empty, no pop. A word pushed in cycle N shows out_vld=1 in cycle N+1.
- Flush (`in_ctrl=1`) has priority over push and pop. Next cycle: count=0 and wr_ptr=rd_ptr=0. A word presented with in_vld in the flush cycle is discarded, not pushed. Flush acts regardless of `stall`.
- `out_ctrl` is `in_ctrl` registered. The fabric therefore sees the flush pulse in the same cycle out_vld is first guaranteed 0.
- The data array is not cleared by reset or flush; only pointers and count are.

## Timing
- Reset values (cycle after `reset` sampled high): count=0, pointers=0, out_vld=0, in_rdy=1 (if stall=0), out_ctrl=0, stat_bp_cnt=0.
- `out_data` contents are unspecified when out_vld=0.
- Reset mid-stream: all held words are lost and out_vld=0 the next cycle. Reset has priority over flush, push and pop.
- Latency: in→out is 1 cycle when empty. Full throughput is 1 word/cycle in steady state with out_rdy=1.
- `stall` high: outputs in_rdy=0 and out_vld=0 combinationally; all state except the flush path is held.

## Configuration
- Macro: `GLB_STRM_FIFO_STATS_EN`.
- Defined: `stat_bp_cnt` increments by 1 each cycle with `in_vld && !in_rdy && !stall`. It saturates at 2^32-1, is cleared by reset, and is not cleared by flush.
- Not defined: the counter is not built and `stat_bp_cnt` is tied to 0.

## Test plan
- Pass-through: DEPTH=4, out_rdy=1, push 0x0001..0x0010 back-to-back. Required: out_data 0x0001..0x0010 in order, first out_vld 1 cycle after first push, no bubbles, count never exceeds 1.
- Fill/backpressure: out_rdy=0, push 0xA0..0xA5. Required: 4 accepted, in_rdy=0 from the cycle count=4 onward. Then out_rdy=1: out_data = 0xA0..0xA3, in_rdy returns 1 the cycle after the first pop, 0xA4 accepted next.
- Simultaneous push/pop at count=2 for 8 cycles: count stays 2 and order is preserved.
- Flush: count=3, pulse in_ctrl with in_vld=1 and in_data=0xBEEF. Required next cycle: count=0, out_vld=0, out_ctrl=1; 0xBEEF never appears.
- Stall and reset: stall=1 for 5 cycles with count=2 → count, head and pointers unchanged, in_rdy=0. Reset asserted at count=3 → count=0 and out_vld=0 next cycle.
- With `GLB_STRM_FIFO_STATS_EN`: full buffer, in_vld=1 for 7 cycles → stat_bp_cnt=7. Without it, stat_bp_cnt=0 throughout.

Source files
------------

// File: rtl/glb_g2f_strm_fifo_if.sv
// GLB-to-fabric stream handshake bundle: GLB-side word/valid/ready/ctrl plus the fabric side.
// master = GLB/fabric environment, slave = the elastic buffer.
interface glb_g2f_strm_fifo_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_vld;
  logic                  in_rdy;
  logic                  in_ctrl;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_vld;
  logic                  out_rdy;
  logic                  out_ctrl;

  modport master (
    output in_data, in_vld, in_ctrl, out_rdy,
    input  in_rdy, out_data, out_vld, out_ctrl
  );

  modport slave (
    input  in_data, in_vld, in_ctrl, out_rdy,
    output in_rdy, out_data, out_vld, out_ctrl
  );
endinterface

// File: rtl/glb_g2f_strm_fifo.sv
// Elastic g2f stream buffer: registered-ready FWFT FIFO with flush on in_ctrl and delayed ctrl.
// Optional backpressure counter built only when GLB_STRM_FIFO_STATS_EN is defined.
module glb_g2f_strm_fifo #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 4,
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  glb_g2f_strm_fifo_if.slave   bus,
  output logic [CNT_WIDTH-1:0] count,
  output logic [31:0]          stat_bp_cnt
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_ctrl;
  logic                  w_full, w_empty, w_push, w_pop;

  assign w_full       = (r_count == CNT_WIDTH'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign bus.in_rdy   = !w_full && !stall;
  assign bus.out_vld  = !w_empty && !stall;
  assign bus.out_data = r_mem[r_rd_ptr];
  assign bus.out_ctrl = r_ctrl;
  assign count        = r_count;

  // Flush wins over both transfers, so the word offered in the flush cycle is dropped.
  assign w_push = bus.in_vld && bus.in_rdy && !bus.in_ctrl;
  assign w_pop  = bus.out_vld && bus.out_rdy && !bus.in_ctrl;

  always_ff @(posedge clk) begin
    if (reset || bus.in_ctrl) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_WIDTH'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_ctrl <= 1'b0;
    else       r_ctrl <= bus.in_ctrl;
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wr_ptr] <= bus.in_data;
  end

`ifdef GLB_STRM_FIFO_STATS_EN
  logic [31:0] r_bp_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_bp_cnt <= '0;
    else if (bus.in_vld && !bus.in_rdy && !stall && (r_bp_cnt != '1))
      r_bp_cnt <= r_bp_cnt + 32'd1;
  end

  assign stat_bp_cnt = r_bp_cnt;
`else
  assign stat_bp_cnt = '0;
`endif
endmodule

// File: tb/tb_glb_g2f_strm_fifo.sv
// Directed bench for glb_g2f_strm_fifo (DEPTH=4, DATA_WIDTH=16); inputs change on negedge.
module tb_glb_g2f_strm_fifo;
  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  count;
  logic [31:0] stat_bp_cnt;
  int          nchk;
  int          nerr;

`ifdef GLB_STRM_FIFO_STATS_EN
  localparam logic [31:0] EXP_BP = 32'd7;
`else
  localparam logic [31:0] EXP_BP = 32'd0;
`endif

  glb_g2f_strm_fifo_if #(.DATA_WIDTH(16)) bus ();

  glb_g2f_strm_fifo #(.DATA_WIDTH(16), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .bus         (bus),
    .count       (count),
    .stat_bp_cnt (stat_bp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0;
    bus.in_vld = 1'b0; bus.in_data = '0; bus.in_ctrl = 1'b0; bus.out_rdy = 1'b0;
    tick(); tick();
    reset = 1'b0; #1;
    nchk++; if (count !== 3'd0) begin nerr++; $display("FAIL rst_count: got %0d exp 0", count); end
    nchk++; if (bus.out_vld !== 1'b0) begin nerr++; $display("FAIL rst_out_vld: got %b exp 0", bus.out_vld); end
    nchk++; if (bus.in_rdy !== 1'b1) begin nerr++; $display("FAIL rst_in_rdy: got %b exp 1", bus.in_rdy); end
    nchk++; if (bus.out_ctrl !== 1'b0) begin nerr++; $display("FAIL rst_out_ctrl: got %b exp 0", bus.out_ctrl); end
    nchk++; if (stat_bp_cnt !== 32'd0) begin nerr++; $display("FAIL rst_stat: got %0d exp 0", stat_bp_cnt); end
  endtask

  task automatic test_pass_through();
    bus.out_rdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.in_vld = 1'b1; bus.in_data = 16'(i); #1;
      nchk++; if (bus.in_rdy !== 1'b1) begin nerr++; $display("FAIL pt_in_rdy[%0d]: got %b exp 1", i, bus.in_rdy); end
      nchk++; if (bus.out_vld !== (i > 1)) begin nerr++; $display("FAIL pt_out_vld[%0d]: got %b exp %b", i, bus.out_vld, (i > 1)); end
      nchk++; if (count !== ((i > 1) ? 3'd1 : 3'd0)) begin nerr++; $display("FAIL pt_count[%0d]: got %0d", i, count); end
      if (i > 1) begin
        nchk++; if (bus.out_data !== 16'(i - 1)) begin nerr++; $display("FAIL pt_data[%0d]: got %h exp %h", i, bus.out_data, 16'(i - 1)); end
      end
      tick();
    end
    bus.in_vld = 1'b0; #1;
    nchk++; if (bus.out_vld !== 1'b1 || bus.out_data !== 16'h0010) begin nerr++; $display("FAIL pt_last: got vld=%b data=%h exp vld=1 data=0010", bus.out_vld, bus.out_data); end
    tick(); #1;
    nchk++; if (count !== 3'd0 || bus.out_vld !== 1'b0) begin nerr++; $display("FAIL pt_drain: got count=%0d vld=%b exp 0/0", count, bus.out_vld); end
    bus.out_rdy = 1'b0;
  endtask

  task automatic test_fill_backpressure();
    bus.out_rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.in_vld = 1'b1; bus.in_data = 16'h00A0 + 16'((c < 4) ? c : 4); #1;
      nchk++; if (bus.in_rdy !== (c < 4)) begin nerr++; $display("FAIL fill_in_rdy[%0d]: got %b exp %b", c, bus.in_rdy, (c < 4)); end
      nchk++; if (count !== 3'((c < 4) ? c : 4)) begin nerr++; $display("FAIL fill_count[%0d]: got %0d exp %0d", c, count, (c < 4) ? c : 4); end
      tick();
    end
    bus.in_data = 16'h00A4; bus.out_rdy = 1'b1; #1;
    nchk++; if (bus.in_rdy !== 1'b0) begin nerr++; $display("FAIL fill_full_rdy: got %b exp 0", bus.in_rdy); end
    nchk++; if (bus.out_data !== 16'h00A0) begin nerr++; $display("FAIL fill_head0: got %h exp 00a0", bus.out_data); end
    tick(); #1;
    nchk++; if (bus.in_rdy !== 1'b1 || count !== 3'd3) begin nerr++; $display("FAIL fill_rdy_back: got rdy=%b count=%0d exp 1/3", bus.in_rdy, count); end
    nchk++; if (bus.out_data !== 16'h00A1) begin nerr++; $display("FAIL fill_head1: got %h exp 00a1", bus.out_data); end
    tick();
    bus.in_vld = 1'b0;
    for (int j = 2; j <= 4; j++) begin
      #1;
      nchk++; if (bus.out_vld !== 1'b1 || bus.out_data !== 16'h00A0 + 16'(j)) begin nerr++; $display("FAIL fill_drain[%0d]: got vld=%b data=%h exp %h", j, bus.out_vld, bus.out_data, 16'h00A0 + 16'(j)); end
      tick();
    end
    #1;
    nchk++; if (count !== 3'd0) begin nerr++; $display("FAIL fill_empty: got %0d exp 0", count); end
    bus.out_rdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.out_rdy = 1'b0; bus.in_vld = 1'b1;
    bus.in_data = 16'h0010; tick();
    bus.in_data = 16'h0011; tick();
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 16'h0012 + 16'(i); #1;
      nchk++; if (count !== 3'd2) begin nerr++; $display("FAIL b2b_count[%0d]: got %0d exp 2", i, count); end
      nchk++; if (bus.out_data !== 16'h0010 + 16'(i)) begin nerr++; $display("FAIL b2b_data[%0d]: got %h exp %h", i, bus.out_data, 16'h0010 + 16'(i)); end
      tick();
    end
    bus.in_vld = 1'b0;
    for (int j = 0; j < 2; j++) begin
      #1;
      nchk++; if (bus.out_data !== 16'h0018 + 16'(j)) begin nerr++; $display("FAIL b2b_tail[%0d]: got %h exp %h", j, bus.out_data, 16'h0018 + 16'(j)); end
      tick();
    end
    #1;
    nchk++; if (count !== 3'd0 || bus.out_vld !== 1'b0) begin nerr++; $display("FAIL b2b_empty: got count=%0d vld=%b exp 0/0", count, bus.out_vld); end
    bus.out_rdy = 1'b0;
  endtask

  task automatic test_flush();
    bus.out_rdy = 1'b0; bus.in_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 16'h00C0 + 16'(i); tick();
    end
    bus.in_data = 16'hBEEF; bus.in_ctrl = 1'b1; #1;
    nchk++; if (count !== 3'd3) begin nerr++; $display("FAIL fl_pre_count: got %0d exp 3", count); end
    tick();
    bus.in_ctrl = 1'b0; bus.in_vld = 1'b0; #1;
    nchk++; if (count !== 3'd0) begin nerr++; $display("FAIL fl_count: got %0d exp 0", count); end
    nchk++; if (bus.out_vld !== 1'b0) begin nerr++; $display("FAIL fl_out_vld: got %b exp 0", bus.out_vld); end
    nchk++; if (bus.out_ctrl !== 1'b1) begin nerr++; $display("FAIL fl_out_ctrl: got %b exp 1", bus.out_ctrl); end
    tick(); #1;
    nchk++; if (bus.out_ctrl !== 1'b0 || bus.out_vld !== 1'b0) begin nerr++; $display("FAIL fl_after: got ctrl=%b vld=%b exp 0/0", bus.out_ctrl, bus.out_vld); end
    bus.in_vld = 1'b1; bus.in_data = 16'h00D1; tick();
    bus.in_vld = 1'b0; bus.out_rdy = 1'b1; #1;
    nchk++; if (count !== 3'd1 || bus.out_data !== 16'h00D1) begin nerr++; $display("FAIL fl_repush: got count=%0d data=%h exp 1/00d1", count, bus.out_data); end
    tick(); #1;
    nchk++; if (count !== 3'd0) begin nerr++; $display("FAIL fl_drain: got %0d exp 0", count); end
    bus.out_rdy = 1'b0;
  endtask

  task automatic test_stall_reset();
    bus.out_rdy = 1'b0; bus.in_vld = 1'b1;
    bus.in_data = 16'h00E0; tick();
    bus.in_data = 16'h00E1; tick();
    stall = 1'b1; bus.in_data = 16'h00EE; bus.out_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      nchk++; if (bus.in_rdy !== 1'b0 || bus.out_vld !== 1'b0) begin nerr++; $display("FAIL st_hs[%0d]: got rdy=%b vld=%b exp 0/0", c, bus.in_rdy, bus.out_vld); end
      nchk++; if (count !== 3'd2) begin nerr++; $display("FAIL st_count[%0d]: got %0d exp 2", c, count); end
      tick();
    end
    stall = 1'b0; bus.in_vld = 1'b0; bus.out_rdy = 1'b0; #1;
    nchk++; if (bus.out_vld !== 1'b1 || bus.out_data !== 16'h00E0) begin nerr++; $display("FAIL st_head: got vld=%b data=%h exp 1/00e0", bus.out_vld, bus.out_data); end
    bus.in_vld = 1'b1; bus.in_data = 16'h00E2; bus.out_rdy = 1'b1; tick();
    bus.in_data = 16'h00E3; bus.out_rdy = 1'b0; #1;
    nchk++; if (count !== 3'd2 || bus.out_data !== 16'h00E1) begin nerr++; $display("FAIL st_resume: got count=%0d data=%h exp 2/00e1", count, bus.out_data); end
    tick();
    reset = 1'b1; bus.in_data = 16'h00E4; bus.out_rdy = 1'b1; #1;
    nchk++; if (count !== 3'd3) begin nerr++; $display("FAIL st_pre_rst: got %0d exp 3", count); end
    tick();
    reset = 1'b0; bus.in_vld = 1'b0; bus.out_rdy = 1'b0; #1;
    nchk++; if (count !== 3'd0 || bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b1) begin nerr++; $display("FAIL st_rst: got count=%0d vld=%b rdy=%b exp 0/0/1", count, bus.out_vld, bus.in_rdy); end
  endtask

  task automatic test_stats();
    bus.out_rdy = 1'b0; bus.in_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 16'h00F0 + 16'(i); tick();
    end
    #1;
    nchk++; if (count !== 3'd4 || stat_bp_cnt !== 32'd0) begin nerr++; $display("FAIL bp_fill: got count=%0d stat=%0d exp 4/0", count, stat_bp_cnt); end
    bus.in_data = 16'h00FF;
    for (int c = 0; c < 7; c++) tick();
    bus.in_vld = 1'b0; #1;
    nchk++; if (stat_bp_cnt !== EXP_BP) begin nerr++; $display("FAIL bp_cnt: got %0d exp %0d", stat_bp_cnt, EXP_BP); end
    bus.in_ctrl = 1'b1; tick();
    bus.in_ctrl = 1'b0; #1;
    nchk++; if (count !== 3'd0 || stat_bp_cnt !== EXP_BP) begin nerr++; $display("FAIL bp_flush: got count=%0d stat=%0d exp 0/%0d", count, stat_bp_cnt, EXP_BP); end
    stall = 1'b1; bus.in_vld = 1'b1; tick(); tick();
    stall = 1'b0; bus.in_vld = 1'b0; #1;
    nchk++; if (stat_bp_cnt !== EXP_BP) begin nerr++; $display("FAIL bp_stall: got %0d exp %0d", stat_bp_cnt, EXP_BP); end
  endtask

  initial begin
    nchk = 0; nerr = 0;
    test_reset();
    test_pass_through();
    test_fill_backpressure();
    test_back_to_back();
    test_flush();
    test_stall_reset();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
